// File: rtl/adma_pkg.sv
// adma_pkg: shared types and constants for the ADMA descriptor fetch unit.
package adma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_READ    = 3'd2,
      ST_DECODE  = 3'd3,
      ST_PRESENT = 3'd4
   } adma_state_e;

   localparam logic [1:0]  ADMA_ACT_NOP  = 2'b00;
   localparam logic [1:0]  ADMA_ACT_RSVD = 2'b01;
   localparam logic [1:0]  ADMA_ACT_TRAN = 2'b10;
   localparam logic [1:0]  ADMA_ACT_LINK = 2'b11;

   localparam int          ADMA_ATTR_VALID  = 0;
   localparam int          ADMA_ATTR_END    = 1;
   localparam int          ADMA_ATTR_INT    = 2;
   localparam int          ADMA_ATTR_ACT_LO = 4;

   localparam int          ADMA_DESC_BYTES = 8;
   localparam logic [15:0] ADMA_MAX_LEN    = 16'd4095;

   // A descriptor is malformed when its valid bit is clear or its length exceeds 12 bits.
   function automatic logic adma_desc_bad(input logic [7:0] attr, input logic [15:0] len);
      return (attr[ADMA_ATTR_VALID] == 1'b0) || (len > ADMA_MAX_LEN);
   endfunction

endpackage

// File: rtl/adma_desc_shreg.sv
// adma_desc_shreg: 8-byte descriptor capture register written one byte at a time.
module adma_desc_shreg (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clr,
   input  logic        i_we,
   input  logic [2:0]  i_idx,
   input  logic [7:0]  i_byte,
   output logic [63:0] o_desc
);

   logic [63:0] r_desc;

   // Capture the addressed byte; clear discards any partially assembled descriptor.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_desc <= 64'd0;
      end else if (i_clr) begin
         r_desc <= 64'd0;
      end else if (i_we) begin
         r_desc[{i_idx, 3'b000} +: 8] <= i_byte;
      end else begin
         r_desc <= r_desc;
      end
   end

   assign o_desc = r_desc;

endmodule

// File: rtl/adma_desc_fetch.sv
// adma_desc_fetch: reads 8-byte ADMA descriptors from RAM, decodes and presents them.
// Optional feature macro: ADMA_LINK_EN (link descriptors are followed, not presented).
module adma_desc_fetch
   import adma_pkg::*;
(
   input  logic        clk_in_1,
   input  logic        reset_1,
   input  logic        start_1,
   input  logic [63:0] desc_base,
   input  logic        fetch_req,
   output logic        ram_rd_o,
   output logic [63:0] ram_addr_o,
   input  logic [7:0]  ram_data_i,
   output logic        valid_2,
   output logic        end_2,
   output logic [1:0]  tran_2,
   output logic        int_2,
   output logic [11:0] block_size,
   output logic [63:0] addr_RAM_i,
   output logic        error_1,
   output logic        fetch_busy
);

   adma_state_e r_state, w_state_next;
   logic [63:0] r_ptr;
   logic [3:0]  r_cnt;
   logic        r_valid, r_end, r_int, r_error;
   logic [1:0]  r_tran;
   logic [11:0] r_blk;
   logic [63:0] r_daddr;

   logic [63:0] w_desc;
   logic [7:0]  w_attr;
   logic [15:0] w_len;
   logic [31:0] w_daddr;
   logic        w_bad, w_is_link, w_we;
   logic        w_unused_bits;

   assign w_attr  = w_desc[7:0];
   assign w_len   = w_desc[31:16];
   assign w_daddr = w_desc[63:32];
   assign w_bad   = adma_desc_bad(w_attr, w_len);
   assign w_unused_bits = ^{w_desc[15:8], w_attr[7:6], w_attr[3]};

`ifdef ADMA_LINK_EN
   assign w_is_link = (w_attr[ADMA_ATTR_ACT_LO +: 2] == ADMA_ACT_LINK);
`else
   assign w_is_link = 1'b0;
`endif

   // RAM data lags the strobe by one cycle, so count N captures byte N-1.
   assign w_we = (r_state == ST_READ) && (r_cnt != 4'd0) && !start_1;

   adma_desc_shreg u_shreg (
      .clk    (clk_in_1),
      .rst    (reset_1),
      .i_clr  (start_1),
      .i_we   (w_we),
      .i_idx  (r_cnt[2:0] - 3'd1),
      .i_byte (ram_data_i),
      .o_desc (w_desc)
   );

   // State register.
   always_ff @(posedge clk_in_1 or posedge reset_1) begin
      if (reset_1) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; start_1 overrides everything, including fetch_req.
   always_comb begin
      w_state_next = r_state;
      if (start_1) begin
         w_state_next = ST_WAIT;
      end else begin
         case (r_state)
            ST_IDLE:    w_state_next = ST_IDLE;
            ST_WAIT:    w_state_next = fetch_req ? ST_READ : ST_WAIT;
            ST_READ:    w_state_next = (r_cnt == 4'd8) ? ST_DECODE : ST_READ;
            ST_DECODE: begin
               if (w_bad) begin
                  w_state_next = ST_IDLE;
               end else if (w_is_link) begin
                  w_state_next = w_attr[ADMA_ATTR_END] ? ST_IDLE : ST_READ;
               end else begin
                  w_state_next = ST_PRESENT;
               end
            end
            ST_PRESENT: w_state_next = r_end ? ST_IDLE : ST_WAIT;
            default:    w_state_next = ST_IDLE;
         endcase
      end
   end

   // Output decode: RAM strobe and address only during the 8 strobe cycles of READ.
   always_comb begin
      ram_rd_o   = 1'b0;
      ram_addr_o = 64'd0;
      fetch_busy = 1'b0;
      case (r_state)
         ST_READ: begin
            fetch_busy = 1'b1;
            if (!r_cnt[3]) begin
               ram_rd_o   = 1'b1;
               ram_addr_o = r_ptr + {60'd0, r_cnt};
            end else begin
               ram_rd_o   = 1'b0;
            end
         end
         ST_DECODE: fetch_busy = 1'b1;
         default:   fetch_busy = 1'b0;
      endcase
   end

   // Datapath: byte counter, descriptor pointer, presented fields and strobes.
   always_ff @(posedge clk_in_1 or posedge reset_1) begin
      if (reset_1) begin
         r_ptr   <= 64'd0;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
         r_error <= 1'b0;
         r_end   <= 1'b0;
         r_int   <= 1'b0;
         r_tran  <= 2'b00;
         r_blk   <= 12'd0;
         r_daddr <= 64'd0;
      end else begin
         r_valid <= 1'b0;
         r_error <= 1'b0;
         if (start_1) begin
            r_ptr <= desc_base;
            r_cnt <= 4'd0;
         end else begin
            case (r_state)
               ST_READ:   r_cnt <= (r_cnt == 4'd8) ? 4'd0 : r_cnt + 4'd1;
               ST_DECODE: begin
                  r_cnt <= 4'd0;
                  if (w_bad) begin
                     r_error <= 1'b1;
                  end else if (w_is_link) begin
                     r_ptr <= {32'd0, w_daddr};
                  end else begin
                     r_valid <= 1'b1;
                     r_end   <= w_attr[ADMA_ATTR_END];
                     r_int   <= w_attr[ADMA_ATTR_INT];
                     r_tran  <= w_attr[ADMA_ATTR_ACT_LO +: 2];
                     r_blk   <= w_len[11:0];
                     r_daddr <= {32'd0, w_daddr};
                     r_ptr   <= r_ptr + 64'd8;
                  end
               end
               default:   r_cnt <= 4'd0;
            endcase
         end
      end
   end

   assign valid_2    = r_valid;
   assign error_1    = r_error;
   assign end_2      = r_end;
   assign int_2      = r_int;
   assign tran_2     = r_tran;
   assign block_size = r_blk;
   assign addr_RAM_i = r_daddr;

endmodule
